// File: rtl/fwft_stream_reader.sv
// Read-side consumer for an FWFT async FIFO: pops head words and re-presents them
// as a valid/ready stream through a 2-entry skid buffer, with a wrapping pop counter.
module fwft_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  pop_count
);

  localparam logic [1:0] OCC_ZERO = 2'd0;
  localparam logic [1:0] OCC_ONE  = 2'd1;
  localparam logic [1:0] OCC_TWO  = 2'd2;

  logic [1:0]            occ_q,   occ_d;
  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
  logic                  pop_s;
  logic                  xfer_s;

  // Pop decision looks only at buffer room, never at m_ready.
  assign pop_s  = rst_n & enable & ~flush & ~fifo_empty & (occ_q != OCC_TWO);
  assign xfer_s = valid_q & m_ready;

  // Next-state for skid buffer slots, occupancy and pop counter.
  always_comb begin
    occ_d   = occ_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    if (pop_s) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    if (flush) begin
      occ_d = OCC_ZERO;
    end else begin
      case (occ_q)
        OCC_ZERO: begin
          if (pop_s) begin
            slot0_d = fifo_data;
            occ_d   = OCC_ONE;
          end else begin
            occ_d   = OCC_ZERO;
          end
        end
        OCC_ONE: begin
          if (pop_s && !xfer_s) begin
            slot1_d = fifo_data;
            occ_d   = OCC_TWO;
          end else if (pop_s && xfer_s) begin
            slot0_d = fifo_data;
            occ_d   = OCC_ONE;
          end else if (xfer_s) begin
            occ_d   = OCC_ZERO;
          end else begin
            occ_d   = OCC_ONE;
          end
        end
        OCC_TWO: begin
          if (xfer_s) begin
            slot0_d = slot1_q;
            occ_d   = OCC_ONE;
          end else begin
            occ_d   = OCC_TWO;
          end
        end
        default: begin
          occ_d = OCC_ZERO;
        end
      endcase
    end
    valid_d = (occ_d != OCC_ZERO);
  end

  // State registers; m_valid is registered alongside occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= OCC_ZERO;
      slot0_q <= {DATA_WIDTH{1'b0}};
      slot1_q <= {DATA_WIDTH{1'b0}};
      valid_q <= 1'b0;
      cnt_q   <= {CNT_WIDTH{1'b0}};
    end else begin
      occ_q   <= occ_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_rd_en = pop_s;
  assign m_valid    = valid_q;
  assign m_data     = slot0_q;
  assign occupancy  = occ_q;
  assign pop_count  = cnt_q;

endmodule

// File: tb/tb_fwft_stream_reader.sv
// Randomized and directed bench for fwft_stream_reader against a queue-based model.
module tb_fwft_stream_reader;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          flush;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [1:0]    occupancy;
  logic [CW-1:0] pop_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fq[$];    // words waiting in the upstream FIFO
  logic [DW-1:0] mbuf[$];  // words the reader is expected to hold, head first
  int            pops = 0;
  bit            hide = 1'b0;

  fwft_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .occupancy(occupancy), .pop_count(pop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0) || hide;
    fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic check_outputs();
    chk("m_valid", {31'd0, m_valid}, {31'd0, mbuf.size() != 0});
    chk("occupancy", {30'd0, occupancy}, mbuf.size());
    chk("pop_count", {28'd0, pop_count}, pops % (1 << CW));
    if (mbuf.size() != 0) chk("m_data", {24'd0, m_data}, {24'd0, mbuf[0]});
  endtask

  // One clock: check pop decision, advance the model across the edge, check outputs.
  task automatic step();
    bit            pop_e;
    bit            xfer_e;
    logic [DW-1:0] d_pre;
    drive_fifo();
    pop_e  = enable && !flush && !fifo_empty && (mbuf.size() < 2);
    xfer_e = (mbuf.size() != 0) && m_ready;
    d_pre  = fifo_data;
    #1;
    chk("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, pop_e});
    @(posedge clk);
    #1;
    if (flush) begin
      mbuf.delete();
    end else begin
      if (xfer_e) void'(mbuf.pop_front());
      if (pop_e) mbuf.push_back(d_pre);
    end
    if (pop_e) begin
      void'(fq.pop_front());
      pops++;
    end
    drive_fifo();
    check_outputs();
  endtask

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(DW'(first + i));
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    mbuf.delete();
    pops = 0;
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_occ", {30'd0, occupancy}, 32'd0);
    chk("rst_data", {24'd0, m_data}, 32'd0);
    chk("rst_cnt", {28'd0, pop_count}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int vcnt;

  initial begin
    rst_n = 1'b0; enable = 1'b1; flush = 1'b0; m_ready = 1'b0;
    drive_fifo();
    #2;
    reset_now();

    // single word
    fq.push_back(8'h3C);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("single_cnt", {28'd0, pop_count}, 32'd1);

    // streaming with no bubbles
    push_words(0, 16);
    vcnt = 0;
    for (int i = 0; i < 18; i++) begin
      step();
      if (m_valid) vcnt++;
    end
    chk("stream_valid_cycles", vcnt, 32'd16);

    // backpressure then toggled ready
    m_ready = 1'b0;
    push_words(0, 8);
    for (int i = 0; i < 5; i++) step();
    chk("bp_occ", {30'd0, occupancy}, 32'd2);
    chk("bp_data", {24'd0, m_data}, 32'd0);
    #1;
    chk("bp_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    for (int i = 0; i < 24; i++) begin
      m_ready = i[0];
      step();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // flush with two buffered words
    m_ready = 1'b0;
    fq.push_back(8'hAA); fq.push_back(8'hBB);
    for (int i = 0; i < 3; i++) step();
    fq.push_back(8'hCC);
    flush = 1'b1;
    step();
    chk("flush_valid", {31'd0, m_valid}, 32'd0);
    flush = 1'b0;
    step();
    chk("post_flush_data", {24'd0, m_data}, 32'hCC);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // enable gating
    enable = 1'b0;
    push_words(8'h40, 4);
    for (int i = 0; i < 4; i++) step();
    enable = 1'b1;
    for (int i = 0; i < 7; i++) step();

    // reset mid-stream, then counter wrap
    push_words(8'h60, 6);
    step(); step();
    reset_now();
    for (int i = 0; i < 4; i++) step();
    fq.delete();
    drive_fifo();
    for (int i = 0; i < 3; i++) step();
    reset_now();
    push_words(8'h80, 17);
    for (int i = 0; i < 20; i++) step();
    chk("wrap_cnt", {28'd0, pop_count}, 32'd1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) push_words($urandom_range(0, 255), $urandom_range(1, 3));
      enable  = ($urandom_range(0, 9) != 0);
      flush   = ($urandom_range(0, 24) == 0);
      m_ready = ($urandom_range(0, 2) != 0);
      hide    = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
